// File: rtl/key_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : key_pkg                                               |
// | Purpose  : Shared types and constants for the key filter block:  |
// |            per-channel state encoding, channel count, default    |
// |            20 ms debounce terminal count, and the priority       |
// |            helper used by the event encoder.                     |
// | Ports    : none (package)                                        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package key_pkg;

  localparam int KEY_NUM      = 4;
  localparam int CNT_MAX_20MS = 999_999;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILTER_DN = 2'd1,
    DOWN      = 2'd2,
    FILTER_UP = 2'd3
  } key_fsm_e;

  // Index of the lowest set bit; 0 when the vector is empty. The
  // loop runs high-to-low so the last hit (lowest index) wins.
  function automatic logic [1:0] lowest_index(input logic [KEY_NUM-1:0] vec);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = i[1:0];
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_filter_1ch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : key_filter_1ch                                        |
// | Purpose  : One push-button channel: 2-FF synchroniser, 4-state   |
// |            debounce FSM with saturating counter, registered      |
// |            one-cycle press/release strobes.                      |
// | Ports    : clk         - system clock                            |
// |            rst_n       - asynchronous active-low reset           |
// |            key_in      - raw key pin, active-low, async to clk   |
// |            key_state   - debounced level, 1 = pressed            |
// |            key_press   - one-cycle strobe on accepted press      |
// |            key_release - one-cycle strobe on accepted release    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module key_filter_1ch
  import key_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_20MS,
  parameter int CNT_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(CNT_MAX);

  logic             r_sync1;
  logic             r_ks;
  key_fsm_e         r_state;
  key_fsm_e         w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_press;
  logic             w_press_nxt;
  logic             r_release;
  logic             w_release_nxt;

  // Synchroniser resets to 1 so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_ks    <= 1'b1;
    end else begin
      r_sync1 <= key_in;
      r_ks    <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Counter is cleared on every state entry and only advances while
  // below terminal count, so it can never wrap.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_ks) begin
          w_state_nxt = FILTER_DN;
          w_cnt_nxt   = '0;
        end
      end
      FILTER_DN: begin
        if (r_ks) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt < c_cnt_max) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end
      end
      DOWN: begin
        if (r_ks) begin
          w_state_nxt = FILTER_UP;
          w_cnt_nxt   = '0;
        end
      end
      FILTER_UP: begin
        if (!r_ks) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
        end else if (r_cnt < c_cnt_max) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pressed level covers DOWN and the release-filter state, so it
  // flips exactly on the edges that also fire the strobes.
  assign key_state   = (r_state == DOWN) || (r_state == FILTER_UP);
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule
`default_nettype wire

// File: rtl/key_filter4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : key_filter4                                           |
// | Purpose  : Four independent debounced key channels plus a        |
// |            registered priority encoder that turns press strobes  |
// |            into a single key event (lowest index wins).          |
// | Ports    : clk         - system clock, 50 MHz                    |
// |            rst_n       - asynchronous active-low reset           |
// |            key_in      - raw keys, active-low                    |
// |            key_state   - debounced levels, 1 = pressed           |
// |            key_press   - per-key one-cycle press strobes         |
// |            key_release - per-key one-cycle release strobes       |
// |            key_valid   - one-cycle event strobe                  |
// |            key_code    - pressed key index, valid with key_valid |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module key_filter4
  import key_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_20MS,
  parameter int CNT_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic               key_valid,
  output logic [1:0]         key_code
);

  logic       r_valid;
  logic [1:0] r_code;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_filter_1ch #(
      .CNT_MAX (CNT_MAX),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

  // key_code is only loaded on an event and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= 2'd0;
    end else begin
      r_valid <= |key_press;
      if (|key_press) begin
        r_code <= lowest_index(key_press);
      end
    end
  end

  assign key_valid = r_valid;
  assign key_code  = r_code;

endmodule
`default_nettype wire
